clk_gate_ctrl: RTL

//  Generates the registered CLK_EN that drives a latch-based clock gate cell from the always-on CLK domain.
//  - Wakes the gated clock on request.
//  - Reports readiness after a programmable settle time.
//  - Keeps the clock on while the gated logic is busy, then for a hang-over window.
//  - Gates the clock off when idle.
//  - Keeps a saturating active-cycle counter for power profiling.

---
 rtl/clk_gate_pkg.sv | 14 +
 rtl/clk_gate_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gate enable controller.
// These are the state encoding and its width, also visible on state_o.
package clk_gate_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        OFF  = 2'b00,
        WAKE = 2'b01,
        ON   = 2'b10,
        HOLD = 2'b11
    } gate_state_e;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Registered enable for a latch-based clock gate cell, running in the always-on CLK domain.
// It handles wake-up with a settle delay, busy hold-on with an idle hang-over, and a saturating active-cycle count.
module clk_gate_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 4,
    parameter int STAT_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_i,
    input  logic              busy_i,
    input  logic              force_on_i,
    input  logic              stat_clr_i,
    output logic              CLK_EN,
    output logic              ready_o,
    output logic [1:0]        state_o,
    output logic [STAT_W-1:0] active_cycles_o
);
    import clk_gate_pkg::*;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    // With no hang-over the load value is never used, so a zero load keeps the constant in range.
    localparam logic [CNT_W-1:0] IDLE_LOAD = (IDLE_CYCLES > 0) ? CNT_W'(IDLE_CYCLES - 1) : '0;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    gate_state_e       state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              clk_en_q, clk_en_nxt;
    logic              ready_q, ready_nxt;
    logic [STAT_W-1:0] stat_q, stat_nxt;
    logic              want;

    assign want = req_i | force_on_i;

    // State register. The outputs are registered here too, so no input reaches a port combinationally.
    // NOTE: every flop takes non-blocking assignments, so all registers sample the same pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
            ready_q  <= 1'b0;
            stat_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            clk_en_q <= clk_en_nxt;
            ready_q  <= ready_nxt;
            stat_q   <= stat_nxt;
        end
    end

    // Next-state and down-counter logic.
    always_comb begin
        // NOTE: defaults first so that every path assigns every signal; a missed branch would otherwise infer a latch.
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            OFF: begin
                // busy_i alone never starts a wake.
                if (want) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // The wake always runs to the end; an idle request is handled once the clock is ON.
                if (cnt_q == '0) begin
                    state_nxt = ON;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ON: begin
                if (!want && !busy_i) begin
                    if (IDLE_CYCLES == 0) begin
                        state_nxt = OFF;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = IDLE_LOAD;
                    end
                end
            end
            HOLD: begin
                // Renewed activity aborts the hang-over, even in the cycle it would expire.
                if (want || busy_i) begin
                    state_nxt = ON;
                end else if (cnt_q == '0) begin
                    state_nxt = OFF;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state. CLK_EN and ready_o are registered together, so they fall in the same cycle.
    always_comb begin
        clk_en_nxt = (state_nxt != OFF);
        ready_nxt  = (state_nxt == ON) || (state_nxt == HOLD);
    end

    // Activity statistic: a clear beats a same-cycle increment, and the count sticks at all-ones.
    always_comb begin
        stat_nxt = stat_q;
        if (stat_clr_i) begin
            stat_nxt = '0;
        end else if (clk_en_q && (stat_q != STAT_MAX)) begin
            stat_nxt = stat_q + 1'b1;
        end
    end

    assign CLK_EN          = clk_en_q;
    assign ready_o         = ready_q;
    assign state_o         = state_q;
    assign active_cycles_o = stat_q;

endmodule
